// File: rtl/hub75_scan_sequencer.sv
// -----------------------------------------------------------------------------
// hub75_scan_sequencer
//
// Purpose:
//   Sequences one sweep of a rotating HUB75 panel. A sweep walks the scan rows
//   0..SCAN_RATE-1 for a single angular slice. For each row the block requests
//   the row pair from the frame manager, offers the row to the HUB75 shifter,
//   waits for the shifter to finish, then blanks the panel while the row
//   address changes. When the sweep ends, the block waits for the IR angle
//   tracker to report a new slice and starts the next sweep.
//
//   The block also counts slices that were lost. A slice is lost when the
//   tracker jumps past the next slice (skip), or when the slice changes before
//   the current sweep has finished (overrun). The count saturates at 255.
//
// Ports:
//   clk_in        : system clock; all state changes on its rising edge
//   rst_in        : synchronous active-high reset
//   enable        : permits new sweeps to start; sampled only in IDLE/WAIT_THETA
//   dtheta        : current angular slice from the angle tracker
//   fetch_req     : row-pair request to the frame manager (held until fetch_ack)
//   fetch_row     : scan row being requested (stable while fetch_req=1)
//   fetch_theta   : slice being requested (stable while fetch_req=1)
//   fetch_ack     : one-cycle pulse, row data valid at the shifter input
//   row_tvalid    : row offered to the shifter (held until row_tready)
//   row_tready    : shifter accepts the row
//   row_done      : one-cycle pulse, shifter finished shifting and latching
//   row_addr      : HUB75 row address, changes only on entry to BLANK
//   blank         : forces panel OE inactive (BLANK and IDLE)
//   sweep_done    : one-cycle pulse when a sweep has finished
//   missed_sweeps : saturating count of skipped or overrun slices
// -----------------------------------------------------------------------------
module hub75_scan_sequencer #(
   parameter int SCAN_RATE      = 32,
   parameter int ROTATIONAL_RES = 256,
   parameter int BLANK_CYCLES   = 4
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic                              enable,
   input  logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
   output logic                              fetch_req,
   output logic [$clog2(SCAN_RATE)-1:0]      fetch_row,
   output logic [$clog2(ROTATIONAL_RES)-1:0] fetch_theta,
   input  logic                              fetch_ack,
   output logic                              row_tvalid,
   input  logic                              row_tready,
   input  logic                              row_done,
   output logic [$clog2(SCAN_RATE)-1:0]      row_addr,
   output logic                              blank,
   output logic                              sweep_done,
   output logic [7:0]                        missed_sweeps
);

   localparam int RW = $clog2(SCAN_RATE);
   localparam int TW = $clog2(ROTATIONAL_RES);

   localparam logic [RW-1:0] LAST_ROW   = RW'(SCAN_RATE - 1);
   localparam logic [TW-1:0] THETA_MAX  = TW'(ROTATIONAL_RES - 1);
   localparam logic [3:0]    BLANK_LAST = 4'(BLANK_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH      = 3'd1,
      ST_SEND       = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_BLANK      = 3'd4,
      ST_WAIT_THETA = 3'd5
   } state_t;

   // Slice that follows t; the top slice wraps to 0 so that a normal
   // revolution rollover is not mistaken for a skip.
   function automatic logic [TW-1:0] theta_succ(input logic [TW-1:0] t);
      logic [TW-1:0] r;
      if (t == THETA_MAX) begin
         r = {TW{1'b0}};
      end else begin
         r = t + TW'(1);
      end
      return r;
   endfunction

   // Registered state
   state_t          state_r;
   logic [RW-1:0]   row_cnt_r;
   logic [TW-1:0]   sweep_theta_r;
   logic [3:0]      blank_cnt_r;
   logic            overrun_seen_r;
   logic [7:0]      missed_r;
   logic            fetch_req_r;
   logic            row_tvalid_r;
   logic [RW-1:0]   row_addr_r;
   logic            blank_r;
   logic            sweep_done_r;

   // Next-state values
   state_t          state_nxt_s;
   logic [RW-1:0]   row_cnt_nxt_s;
   logic [TW-1:0]   theta_nxt_s;
   logic [3:0]      blank_cnt_nxt_s;
   logic            overrun_nxt_s;
   logic [7:0]      missed_nxt_s;
   logic [RW-1:0]   row_addr_nxt_s;
   logic            sweep_done_nxt_s;
   logic            skip_s;
   logic            in_sweep_s;
   logic            overrun_now_s;

   // Next-state, counters and slice-loss detection
   always_comb begin
      state_nxt_s      = state_r;
      row_cnt_nxt_s    = row_cnt_r;
      theta_nxt_s      = sweep_theta_r;
      blank_cnt_nxt_s  = blank_cnt_r;
      overrun_nxt_s    = overrun_seen_r;
      missed_nxt_s     = missed_r;
      row_addr_nxt_s   = row_addr_r;
      sweep_done_nxt_s = 1'b0;
      skip_s           = 1'b0;
      in_sweep_s       = 1'b0;
      overrun_now_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            // First sweep after idling: nothing to compare against, so no
            // skip check here.
            if (enable) begin
               theta_nxt_s   = dtheta;
               row_cnt_nxt_s = {RW{1'b0}};
               overrun_nxt_s = 1'b0;
               state_nxt_s   = ST_FETCH;
            end else begin
               state_nxt_s   = ST_IDLE;
            end
         end

         ST_FETCH: begin
            in_sweep_s = 1'b1;
            if (fetch_ack) begin
               state_nxt_s = ST_SEND;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end

         ST_SEND: begin
            in_sweep_s = 1'b1;
            // row_tvalid is always 1 in this state, so tready alone accepts.
            if (row_tready) begin
               state_nxt_s = ST_WAIT_DONE;
            end else begin
               state_nxt_s = ST_SEND;
            end
         end

         ST_WAIT_DONE: begin
            in_sweep_s = 1'b1;
            if (row_done) begin
               row_addr_nxt_s  = row_cnt_r;
               blank_cnt_nxt_s = 4'd0;
               state_nxt_s     = ST_BLANK;
            end else begin
               state_nxt_s     = ST_WAIT_DONE;
            end
         end

         ST_BLANK: begin
            in_sweep_s = 1'b1;
            // blank_cnt_r runs 0..BLANK_CYCLES-1, one count per blank cycle.
            if (blank_cnt_r == BLANK_LAST) begin
               if (row_cnt_r == LAST_ROW) begin
                  sweep_done_nxt_s = 1'b1;
                  state_nxt_s      = ST_WAIT_THETA;
               end else begin
                  row_cnt_nxt_s    = row_cnt_r + RW'(1);
                  state_nxt_s      = ST_FETCH;
               end
            end else begin
               blank_cnt_nxt_s = blank_cnt_r + 4'd1;
               state_nxt_s     = ST_BLANK;
            end
         end

         ST_WAIT_THETA: begin
            if (!enable) begin
               state_nxt_s = ST_IDLE;
            end else if (dtheta != sweep_theta_r) begin
               skip_s        = (dtheta != theta_succ(sweep_theta_r));
               theta_nxt_s   = dtheta;
               row_cnt_nxt_s = {RW{1'b0}};
               overrun_nxt_s = 1'b0;
               state_nxt_s   = ST_FETCH;
            end else begin
               state_nxt_s   = ST_WAIT_THETA;
            end
         end

         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      // A slice change while the sweep is still running is charged once per
      // sweep; the sweep itself carries on with the latched slice.
      if (in_sweep_s && !overrun_seen_r && (dtheta != sweep_theta_r)) begin
         overrun_now_s = 1'b1;
         overrun_nxt_s = 1'b1;
      end else begin
         overrun_now_s = 1'b0;
      end

      // Skip and overrun on the same edge still count as one lost slice.
      if ((skip_s || overrun_now_s) && (missed_r != 8'hFF)) begin
         missed_nxt_s = missed_r + 8'd1;
      end else begin
         missed_nxt_s = missed_r;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r        <= ST_IDLE;
         row_cnt_r      <= {RW{1'b0}};
         sweep_theta_r  <= {TW{1'b0}};
         blank_cnt_r    <= 4'd0;
         overrun_seen_r <= 1'b0;
         missed_r       <= 8'd0;
         fetch_req_r    <= 1'b0;
         row_tvalid_r   <= 1'b0;
         row_addr_r     <= {RW{1'b0}};
         blank_r        <= 1'b1;
         sweep_done_r   <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         row_cnt_r      <= row_cnt_nxt_s;
         sweep_theta_r  <= theta_nxt_s;
         blank_cnt_r    <= blank_cnt_nxt_s;
         overrun_seen_r <= overrun_nxt_s;
         missed_r       <= missed_nxt_s;
         // Outputs are decoded from the next state so they line up with the
         // state register while still coming straight out of flops.
         fetch_req_r    <= (state_nxt_s == ST_FETCH);
         row_tvalid_r   <= (state_nxt_s == ST_SEND);
         row_addr_r     <= row_addr_nxt_s;
         blank_r        <= (state_nxt_s == ST_BLANK) || (state_nxt_s == ST_IDLE);
         sweep_done_r   <= sweep_done_nxt_s;
      end
   end

   assign fetch_req     = fetch_req_r;
   assign fetch_row     = row_cnt_r;
   assign fetch_theta   = sweep_theta_r;
   assign row_tvalid    = row_tvalid_r;
   assign row_addr      = row_addr_r;
   assign blank         = blank_r;
   assign sweep_done    = sweep_done_r;
   assign missed_sweeps = missed_r;

endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hub75_scan_sequencer
//
// Self-checking bench for hub75_scan_sequencer. All stimulus, response and
// monitoring run from one thread: every cycle() waits for the rising edge,
// settles 1 time unit, checks the DUT outputs against the scoreboard, then
// drives the frame-manager / shifter responses for the next edge.
// -----------------------------------------------------------------------------
module tb_hub75_scan_sequencer;

   localparam int SCAN_RATE = 32;
   localparam int ROT_RES   = 256;
   localparam int BC        = 4;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       enable;
   logic [7:0] dtheta;
   logic       fetch_req;
   logic [4:0] fetch_row;
   logic [7:0] fetch_theta;
   logic       fetch_ack;
   logic       row_tvalid;
   logic       row_tready;
   logic       row_done;
   logic [4:0] row_addr;
   logic       blank;
   logic       sweep_done;
   logic [7:0] missed_sweeps;

   always #5 clk_in = ~clk_in;

   hub75_scan_sequencer #(
      .SCAN_RATE     (SCAN_RATE),
      .ROTATIONAL_RES(ROT_RES),
      .BLANK_CYCLES  (BC)
   ) u_dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .enable       (enable),
      .dtheta       (dtheta),
      .fetch_req    (fetch_req),
      .fetch_row    (fetch_row),
      .fetch_theta  (fetch_theta),
      .fetch_ack    (fetch_ack),
      .row_tvalid   (row_tvalid),
      .row_tready   (row_tready),
      .row_done     (row_done),
      .row_addr     (row_addr),
      .blank        (blank),
      .sweep_done   (sweep_done),
      .missed_sweeps(missed_sweeps)
   );

   typedef struct {
      logic [4:0] row;
      logic [7:0] theta;
   } fetch_t;

   typedef struct {
      logic [7:0] theta;
      logic [7:0] exp_missed;
   } vec_t;

   fetch_t sb[$];
   vec_t   vecs[7];

   int n_checks = 0;
   int n_errors = 0;

   // responder controls
   logic auto_ack, auto_ready, force_ack, pend_done;

   // monitor state
   logic       prev_fetch_req, prev_blank, prev_tvalid, prev_sweep_done;
   logic [4:0] prev_row_addr;
   logic       in_sweep, blanking;
   int         blank_run;
   logic [4:0] exp_row;
   logic [7:0] exp_theta;
   int         fetch_total;
   int         n_sweep_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_fail(input string name, input string msg);
      n_checks++;
      n_errors++;
      $display("FAIL %s: %s (t=%0t)", name, msg, $time);
   endtask

   task automatic push_sweep(input logic [7:0] theta);
      fetch_t e;
      for (int r = 0; r < SCAN_RATE; r++) begin
         e.row   = 5'(r);
         e.theta = theta;
         sb.push_back(e);
      end
   endtask

   // One clock: observe outputs after the edge, then drive responses.
   task automatic cycle();
      fetch_t e;
      @(posedge clk_in);
      #1;
      if (rst_in) begin
         sb.delete();
         in_sweep = 1'b0;
         blanking = 1'b0;
      end else begin
         if (fetch_req && !prev_fetch_req) begin
            fetch_total++;
            in_sweep = 1'b1;
            if (sb.size() == 0) begin
               flag_fail("unexpected_fetch", $sformatf("row %0d theta %0d, none expected", fetch_row, fetch_theta));
            end else begin
               e = sb.pop_front();
               exp_row   = e.row;
               exp_theta = e.theta;
               chk("fetch_row", fetch_row, exp_row);
               chk("fetch_theta", fetch_theta, exp_theta);
            end
         end else if (fetch_req && prev_fetch_req) begin
            chk("fetch_row_hold", fetch_row, exp_row);
            chk("fetch_theta_hold", fetch_theta, exp_theta);
         end

         if (blank && !prev_blank && in_sweep) begin
            blanking  = 1'b1;
            blank_run = 1;
            chk("row_addr_on_blank", row_addr, exp_row);
         end else if (blanking) begin
            if (blank) begin
               blank_run++;
            end else begin
               chk("blank_len", blank_run, BC);
               blanking = 1'b0;
            end
         end

         if ((row_addr !== prev_row_addr) && !(blank && !prev_blank)) begin
            flag_fail("row_addr_change", $sformatf("changed to %0d outside BLANK entry", row_addr));
         end
         if (prev_tvalid && !row_tvalid && !row_tready) begin
            flag_fail("tvalid_drop", "row_tvalid dropped without acceptance");
         end
         if (sweep_done) begin
            n_sweep_done++;
            in_sweep = 1'b0;
            if (prev_sweep_done) begin
               flag_fail("sweep_done_pulse", "sweep_done high two cycles in a row");
            end
         end
      end
      prev_fetch_req  = fetch_req;
      prev_blank      = blank;
      prev_tvalid     = row_tvalid;
      prev_sweep_done = sweep_done;
      prev_row_addr   = row_addr;

      // responder for the next edge
      row_done   = pend_done;
      fetch_ack  = (auto_ack && fetch_req) || force_ack;
      force_ack  = 1'b0;
      row_tready = auto_ready && row_tvalid;
      pend_done  = row_tvalid && row_tready;
   endtask

   task automatic wait_sweep_done(input string name, input int budget);
      int k = 0;
      do begin
         cycle();
         k++;
      end while (!sweep_done && k < budget);
      if (!sweep_done) flag_fail(name, "timeout waiting for sweep_done");
   endtask

   task automatic wait_fetches(input int target, input int budget);
      int k = 0;
      while (fetch_total < target && k < budget) begin
         cycle();
         k++;
      end
      if (fetch_total < target) flag_fail("wait_fetches", "timeout waiting for fetches");
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      enable = 1'b0;
      cycle();
      cycle();
      rst_in = 1'b0;
   endtask

   initial begin
      int         k;
      int         base;
      int         sd0;
      logic [7:0] cur;
      int         model;

      rst_in = 1'b1; enable = 1'b0; dtheta = 8'd0;
      fetch_ack = 1'b0; row_tready = 1'b0; row_done = 1'b0;
      auto_ack = 1'b1; auto_ready = 1'b1; force_ack = 1'b0; pend_done = 1'b0;
      prev_fetch_req = 1'b0; prev_blank = 1'b1; prev_tvalid = 1'b0;
      prev_sweep_done = 1'b0; prev_row_addr = 5'd0;
      in_sweep = 1'b0; blanking = 1'b0; blank_run = 0;
      exp_row = 5'd0; exp_theta = 8'd0; fetch_total = 0; n_sweep_done = 0;

      vecs[0] = '{8'd254, 8'd1};   // 6 -> 254 skip
      vecs[1] = '{8'd255, 8'd1};   // consecutive
      vecs[2] = '{8'd0,   8'd1};   // wrap, not a skip
      vecs[3] = '{8'd10,  8'd2};   // skip
      vecs[4] = '{8'd12,  8'd3};   // 10 -> 12 skip
      vecs[5] = '{8'd13,  8'd3};   // consecutive
      vecs[6] = '{8'd12,  8'd4};   // backwards counts as skip

      // ---- reset state
      do_reset();
      chk("rst_fetch_req", fetch_req, 0);
      chk("rst_tvalid", row_tvalid, 0);
      chk("rst_row_addr", row_addr, 0);
      chk("rst_blank", blank, 1);
      chk("rst_sweep_done", sweep_done, 0);
      chk("rst_missed", missed_sweeps, 0);

      // ---- nominal sweep at theta 5
      dtheta = 8'd5; enable = 1'b1;
      push_sweep(8'd5);
      sd0 = n_sweep_done;
      base = fetch_total;
      wait_sweep_done("nom_sweep", 3000);
      chk("nom_fetch_count", fetch_total - base, SCAN_RATE);
      chk("nom_sb_empty", sb.size(), 0);
      chk("nom_row_addr", row_addr, 31);
      chk("nom_blank_wait_theta", blank, 0);
      chk("nom_missed", missed_sweeps, 0);
      repeat (20) cycle();
      chk("nom_one_sweep_done", n_sweep_done - sd0, 1);
      chk("nom_idle_fetch", fetch_req, 0);

      // ---- backpressure on the first row of the theta 6 sweep
      auto_ready = 1'b0;
      dtheta = 8'd6;
      push_sweep(8'd6);
      k = 0;
      do begin cycle(); k++; end while (!row_tvalid && k < 20);
      if (!row_tvalid) flag_fail("bp_tvalid_rise", "timeout waiting for row_tvalid");
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("bp_tvalid", row_tvalid, 1);
         chk("bp_no_fetch", fetch_req, 0);
         chk("bp_blank", blank, 0);
      end
      auto_ready = 1'b1;
      cycle();               // row_tready driven high after this edge
      cycle();               // accepted on this edge
      chk("bp_accept", row_tvalid, 0);
      wait_sweep_done("bp_sweep", 3000);
      chk("bp_missed", missed_sweeps, 0);

      // ---- slice transition table
      for (int v = 0; v < 7; v++) begin
         dtheta = vecs[v].theta;
         push_sweep(vecs[v].theta);
         cycle();
         chk($sformatf("table_missed_%0d", v), missed_sweeps, vecs[v].exp_missed);
         wait_sweep_done($sformatf("table_sweep_%0d", v), 3000);
      end

      // ---- overrun: 5 -> 6 mid-sweep
      do_reset();
      dtheta = 8'd5; enable = 1'b1;
      push_sweep(8'd5);
      base = fetch_total;
      wait_fetches(base + 6, 200);
      dtheta = 8'd6;
      cycle();
      chk("ovr_missed_now", missed_sweeps, 1);
      wait_sweep_done("ovr_sweep", 3000);
      chk("ovr_sb_empty", sb.size(), 0);
      chk("ovr_missed_end", missed_sweeps, 1);

      // ---- next sweep (theta 6, consecutive) with enable dropped at row 10
      push_sweep(8'd6);
      base = fetch_total;
      cycle();
      chk("drop_missed_start", missed_sweeps, 1);
      k = 0;
      while (!(fetch_req && fetch_row == 5'd10) && k < 500) begin cycle(); k++; end
      if (!(fetch_req && fetch_row == 5'd10)) flag_fail("drop_row10", "row 10 fetch not seen");
      enable = 1'b0;
      wait_sweep_done("drop_sweep", 3000);
      chk("drop_fetch_count", fetch_total - base, SCAN_RATE);
      chk("drop_row_addr", row_addr, 31);
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("drop_no_fetch", fetch_req, 0);
      end
      chk("drop_idle_blank", blank, 1);
      chk("drop_missed", missed_sweeps, 1);

      // ---- reset mid-FETCH, then a late fetch_ack
      auto_ack = 1'b0;
      dtheta = 8'd9; enable = 1'b1;
      push_sweep(8'd9);
      k = 0;
      do begin cycle(); k++; end while (!fetch_req && k < 20);
      if (!fetch_req) flag_fail("rf_fetch_req", "timeout waiting for fetch_req");
      cycle();
      cycle();
      rst_in = 1'b1; enable = 1'b0;
      cycle();
      rst_in = 1'b0;
      chk("rf_fetch_req", fetch_req, 0);
      chk("rf_blank", blank, 1);
      chk("rf_row_addr", row_addr, 0);
      chk("rf_missed", missed_sweeps, 0);
      chk("rf_tvalid", row_tvalid, 0);
      chk("rf_sweep_done", sweep_done, 0);
      force_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("rf_late_ack_fetch", fetch_req, 0);
         chk("rf_late_ack_tvalid", row_tvalid, 0);
         chk("rf_late_ack_blank", blank, 1);
      end
      auto_ack = 1'b1;

      // ---- saturation: each sweep gets one overrun and one skip
      model = 0;
      cur = 8'd0;
      dtheta = cur; enable = 1'b1;
      push_sweep(cur);
      for (int it = 0; it < 150; it++) begin
         base = fetch_total;
         wait_fetches(base + 3, 200);
         dtheta = cur + 8'd3;
         if (model < 255) model++;
         wait_sweep_done("sat_sweep", 3000);
         cur = cur + 8'd2;
         dtheta = cur;
         push_sweep(cur);
         if (model < 255) model++;
         cycle();
         chk($sformatf("sat_missed_%0d", it), missed_sweeps, model);
         if (n_errors > 20) break;
      end
      enable = 1'b0;
      wait_sweep_done("sat_last", 3000);
      chk("sat_final", missed_sweeps, 255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
